// File: rtl/wb_uart_master_pkg.sv
// Shared constants and FSM encoding for the UART-driven Wishbone master.
// Opcodes and reply bytes are the host-visible protocol; the state enum is internal.
package wb_uart_master_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS_REQ,
    S_BUS_WAIT,
    S_RESP_LOAD,
    S_RESP
  } state_t;

endpackage

// File: rtl/wb_uart_tx_serializer.sv
// Sends up to four bytes MSB first, one pulse per transmitter-idle window,
// never in two consecutive cycles; o_done is high while nothing is pending.
module wb_uart_tx_serializer (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic [31:0] i_bytes,
  input  logic [2:0]  i_len,
  input  logic        i_busy,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  output logic        o_done
);

  logic [31:0] r_buf;
  logic [2:0]  r_left;
  logic        r_prev_valid;
  logic        w_fire;

  // Pacing gate: busy is sampled in the pulse cycle itself, so the transmitter
  // sees a pulse only while it reports idle.
  assign w_fire     = (r_left != 3'd0) && !i_busy && !r_prev_valid;
  assign o_tx_valid = w_fire;
  assign o_tx_data  = w_fire ? r_buf[31:24] : 8'h00;
  assign o_done     = (r_left == 3'd0);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register in this block sees the values from before the clock edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_buf        <= 32'h0;
      r_left       <= 3'd0;
      r_prev_valid <= 1'b0;
    end else begin
      r_prev_valid <= w_fire;
      if (i_load) begin
        r_buf  <= i_bytes;
        r_left <= i_len;
      end else if (w_fire) begin
        r_buf  <= {r_buf[23:0], 8'h00};
        r_left <= r_left - 3'd1;
      end
    end
  end

endmodule

// File: rtl/wb_uart_master.sv
// Wishbone master fed by framed byte commands ('W' addr data / 'R' addr);
// runs one single-beat pipelined bus cycle per command and replies over the byte link.
module wb_uart_master
  import wb_uart_master_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024,
  parameter int IDLE_CYC    = 50000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_byte_rx_data,
  input  logic        i_byte_rx_valid,
  output logic [7:0]  o_byte_tx_data,
  output logic        o_byte_tx_valid,
  input  logic        i_byte_tx_busy,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  output logic [3:0]  o_wb_sel,
  input  logic        i_wb_stall,
  input  logic        i_wb_ack,
  input  logic [31:0] i_wb_data
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int ID_W = $clog2(IDLE_CYC + 1);

  state_t          r_state, w_state_nxt;
  logic [31:0]     r_addr, r_wdata, r_rdata;
  logic            r_we, r_err;
  logic [1:0]      r_byte_cnt;
  logic [ID_W-1:0] r_idle_cnt;
  logic [TO_W-1:0] r_to_cnt;

  logic            w_in_frame, w_idle_exp, w_to_exp, w_ack_take;
  logic            w_load, w_done;
  logic [31:0]     w_rsp_bytes;
  logic [2:0]      w_rsp_len;

  assign w_in_frame = (r_state == S_ADDR) || (r_state == S_DATA);
  assign w_idle_exp = !i_byte_rx_valid && (r_idle_cnt == ID_W'(IDLE_CYC - 1));
  assign w_to_exp   = (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
  // An ack while the request is still stalled is not a valid completion.
  assign w_ack_take = i_wb_ack && ((r_state == S_BUS_WAIT) ||
                                   (r_state == S_BUS_REQ && !i_wb_stall));

  assign o_wb_cyc  = (r_state == S_BUS_REQ) || (r_state == S_BUS_WAIT);
  assign o_wb_stb  = (r_state == S_BUS_REQ);
  assign o_wb_we   = r_we && o_wb_cyc;
  assign o_wb_addr = r_addr;
  assign o_wb_data = r_wdata;
  assign o_wb_sel  = 4'hF;

  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:
        if (i_byte_rx_valid && (i_byte_rx_data == CMD_WR || i_byte_rx_data == CMD_RD))
          w_state_nxt = S_ADDR;
      S_ADDR:
        if (i_byte_rx_valid && r_byte_cnt == 2'd3) w_state_nxt = r_we ? S_DATA : S_BUS_REQ;
        else if (w_idle_exp)                       w_state_nxt = S_IDLE;
      S_DATA:
        if (i_byte_rx_valid && r_byte_cnt == 2'd3) w_state_nxt = S_BUS_REQ;
        else if (w_idle_exp)                       w_state_nxt = S_IDLE;
      S_BUS_REQ:
        if (w_ack_take || w_to_exp) w_state_nxt = S_RESP_LOAD;
        else if (!i_wb_stall)       w_state_nxt = S_BUS_WAIT;
      S_BUS_WAIT:
        if (w_ack_take || w_to_exp) w_state_nxt = S_RESP_LOAD;
      S_RESP_LOAD: w_state_nxt = S_RESP;
      S_RESP:      if (w_done) w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_addr     <= 32'h0;
      r_wdata    <= 32'h0;
      r_rdata    <= 32'h0;
      r_we       <= 1'b0;
      r_err      <= 1'b0;
      r_byte_cnt <= 2'd0;
      r_idle_cnt <= '0;
      r_to_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (r_state == S_IDLE && i_byte_rx_valid &&
          (i_byte_rx_data == CMD_WR || i_byte_rx_data == CMD_RD)) begin
        r_we       <= (i_byte_rx_data == CMD_WR);
        r_err      <= 1'b0;
        r_byte_cnt <= 2'd0;
      end

      if (w_in_frame && i_byte_rx_valid) begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
        if (r_state == S_ADDR) r_addr  <= {r_addr[23:0], i_byte_rx_data};
        else                   r_wdata <= {r_wdata[23:0], i_byte_rx_data};
      end

      if (w_in_frame && !i_byte_rx_valid) r_idle_cnt <= r_idle_cnt + ID_W'(1);
      else                                r_idle_cnt <= '0;

      if (o_wb_cyc) r_to_cnt <= r_to_cnt + TO_W'(1);
      else          r_to_cnt <= '0;

      if (w_ack_take)                           r_rdata <= i_wb_data;
      if (o_wb_cyc && w_to_exp && !w_ack_take)  r_err   <= 1'b1;
    end
  end

  assign w_load      = (r_state == S_RESP_LOAD);
  assign w_rsp_bytes = r_err ? {RSP_ERR, 24'h0} : (r_we ? {RSP_OK, 24'h0} : r_rdata);
  assign w_rsp_len   = (r_err || r_we) ? 3'd1 : 3'd4;

  wb_uart_tx_serializer u_tx_ser (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_load),
    .i_bytes    (w_rsp_bytes),
    .i_len      (w_rsp_len),
    .i_busy     (i_byte_tx_busy),
    .o_tx_data  (o_byte_tx_data),
    .o_tx_valid (o_byte_tx_valid),
    .o_done     (w_done)
  );

endmodule
